// File: rtl/elevator_pkg.sv
// Shared elevator types: direction encoding, floor-sensor codes and FSM states.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    RSVD = 2'b11
  } dir_t;

  localparam logic [1:0] FS_NONE = 2'b00;
  localparam logic [1:0] FS_F1   = 2'b01;
  localparam logic [1:0] FS_F2   = 2'b10;
  localparam logic [1:0] FS_F3   = 2'b11;

  typedef enum logic {
    AT_FLOOR = 1'b0,
    TRANSIT  = 1'b1
  } fs_state_t;

  function automatic logic [1:0] fs_encode(input logic [1:0] floor);
    case (floor)
      2'd1:    fs_encode = FS_F1;
      2'd2:    fs_encode = FS_F2;
      2'd3:    fs_encode = FS_F3;
      default: fs_encode = FS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/floor_sensor_timer.sv
// Loadable down-counter that saturates at zero; zero flag reflects the registered count.
module floor_sensor_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/floor_sensor.sv
// Elevator shaft position sensor plant model: drives fs/moving/err from dir/door.
// Define DOOR_SENSE_EN to add the door-closed sensor output dc and gate departure on it.
module floor_sensor
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 20,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir,
  input  logic       door,
  output logic [1:0] fs,
  output logic       moving,
  output logic       err
`ifdef DOOR_SENSE_EN
  ,
  output logic       dc
`endif
);

  localparam logic [7:0] TRAVEL_LD = 8'(TRAVEL_CYCLES - 1);

  if (TRAVEL_CYCLES < 2 || TRAVEL_CYCLES > 255 || DOOR_CYCLES < 1 || DOOR_CYCLES > 255)
  begin : g_bad_param
    $error("floor_sensor: TRAVEL_CYCLES/DOOR_CYCLES out of range");
  end

  fs_state_t  state, state_n;
  logic [1:0] floor, floor_n;
  logic [1:0] target, target_n;
  logic [1:0] fs_n;
  logic       moving_n, err_n;
  logic       t_load, t_dec, t_zero;
  logic       closed;
  dir_t       d;

  assign d = dir_t'(dir);

`ifdef DOOR_SENSE_EN
  localparam logic [7:0] DOOR_LD = 8'(DOOR_CYCLES - 1);
  logic d_zero;

  // Held loaded while the door is open, so a re-open restarts the close sequence.
  floor_sensor_timer #(.W(8)) u_door_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (door),
    .load_val (DOOR_LD),
    .dec      (!door && !dc),
    .zero     (d_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              dc <= 1'b1;
    else if (door)         dc <= 1'b0;
    else if (!dc && d_zero) dc <= 1'b1;
  end

  assign closed = dc;
`else
  assign closed = !door;
`endif

  floor_sensor_timer #(.W(8)) u_travel_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (TRAVEL_LD),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= AT_FLOOR;
      floor  <= 2'd1;
      target <= 2'd1;
      fs     <= FS_F1;
      moving <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      floor  <= floor_n;
      target <= target_n;
      fs     <= fs_n;
      moving <= moving_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    floor_n  = floor;
    target_n = target;
    fs_n     = fs;
    moving_n = moving;
    err_n    = err;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    case (state)
      AT_FLOOR: begin
        if (d == UP || d == DOWN) begin
          if ((d == UP && floor == 2'd3) || (d == DOWN && floor == 2'd1)) begin
            err_n = 1'b1;
          end else if (door) begin
            err_n = 1'b1;
          end else if (closed) begin
            target_n = (d == UP) ? floor + 2'd1 : floor - 2'd1;
            t_load   = 1'b1;
            fs_n     = FS_NONE;
            moving_n = 1'b1;
            state_n  = TRANSIT;
          end
        end
      end
      TRANSIT: begin
        // Travel is committed: dir is ignored, an open door only flags the error.
        if (door) err_n = 1'b1;
        if (t_zero) begin
          floor_n  = target;
          fs_n     = fs_encode(target);
          moving_n = 1'b0;
          state_n  = AT_FLOOR;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: state_n = AT_FLOOR;
    endcase
  end

endmodule

// File: tb/tb_floor_sensor.sv
// Directed bench for floor_sensor: vector table plus hand sequences for reset/interlock/door sensor.
module tb_floor_sensor;

  logic       clk;
  logic       rst;
  logic [1:0] dir;
  logic       door;
  logic [1:0] fs;
  logic       moving;
  logic       err;
`ifdef DOOR_SENSE_EN
  logic       dc;
`endif

  int n_cmp;
  int n_bad;

  floor_sensor #(.TRAVEL_CYCLES(20), .DOOR_CYCLES(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .dir    (dir),
    .door   (door),
    .fs     (fs),
    .moving (moving),
    .err    (err)
`ifdef DOOR_SENSE_EN
    ,
    .dc     (dc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dir;
    logic       door;
    int         n;
    logic [1:0] fs;
    logic       mv;
    logic       er;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic [1:0] di, input logic dr, input int n,
                              input logic [1:0] f, input logic m, input logic e);
    vec_t v;
    v.dir = di; v.door = dr; v.n = n; v.fs = f; v.mv = m; v.er = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] ef, input logic em, input logic ee);
    n_cmp++;
    if (fs !== ef || moving !== em || err !== ee) begin
      n_bad++;
      $display("FAIL %s: got fs=%b moving=%b err=%b, want fs=%b moving=%b err=%b",
               name, fs, moving, err, ef, em, ee);
    end
  endtask

  // Drive at a negedge, run n rising edges, return to the following negedge.
  task automatic step(input logic [1:0] di, input logic dr, input int n);
    dir  = di;
    door = dr;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    dir = 2'b00;
    door = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    dir = 2'b00;
    door = 1'b0;

    // Floor1 up (reversal ignored mid-transit), down again, then up to floor3 and overrun.
    vt[0]  = mk(2'b01, 1'b0, 1,  2'b00, 1'b1, 1'b0);
    vt[1]  = mk(2'b10, 1'b0, 19, 2'b00, 1'b1, 1'b0);
    vt[2]  = mk(2'b10, 1'b0, 1,  2'b10, 1'b0, 1'b0);
    vt[3]  = mk(2'b10, 1'b0, 1,  2'b00, 1'b1, 1'b0);
    vt[4]  = mk(2'b00, 1'b0, 19, 2'b00, 1'b1, 1'b0);
    vt[5]  = mk(2'b00, 1'b0, 1,  2'b01, 1'b0, 1'b0);
    vt[6]  = mk(2'b01, 1'b0, 1,  2'b00, 1'b1, 1'b0);
    vt[7]  = mk(2'b01, 1'b0, 19, 2'b00, 1'b1, 1'b0);
    vt[8]  = mk(2'b01, 1'b0, 1,  2'b10, 1'b0, 1'b0);
    vt[9]  = mk(2'b01, 1'b0, 1,  2'b00, 1'b1, 1'b0);
    vt[10] = mk(2'b01, 1'b0, 19, 2'b00, 1'b1, 1'b0);
    vt[11] = mk(2'b01, 1'b0, 1,  2'b11, 1'b0, 1'b0);
    vt[12] = mk(2'b01, 1'b0, 1,  2'b11, 1'b0, 1'b1);
    vt[13] = mk(2'b11, 1'b0, 3,  2'b11, 1'b0, 1'b1);
    vt[14] = mk(2'b10, 1'b1, 1,  2'b11, 1'b0, 1'b1);

    @(negedge clk);
    check("reset_state", 2'b01, 1'b0, 1'b0);
    do_reset();
    check("after_reset", 2'b01, 1'b0, 1'b0);

    for (int i = 0; i < 50; i++) begin
      step(2'b00, 1'b0, 1);
      check("idle_hold", 2'b01, 1'b0, 1'b0);
    end

    for (int i = 0; i < 15; i++) begin
      step(vt[i].dir, vt[i].door, vt[i].n);
      check($sformatf("vec%0d", i), vt[i].fs, vt[i].mv, vt[i].er);
    end

    // Down at floor 1 is a limit overrun.
    do_reset();
    step(2'b10, 1'b0, 1);
    check("limit_floor1", 2'b01, 1'b0, 1'b1);

    // Direction with door open: interlock error, no departure.
    do_reset();
    step(2'b01, 1'b1, 1);
    check("interlock", 2'b01, 1'b0, 1'b1);
    step(2'b01, 1'b1, 3);
    check("interlock_hold", 2'b01, 1'b0, 1'b1);

    // Door opened mid-transit: error but travel still completes on time.
    do_reset();
    step(2'b01, 1'b0, 1);
    step(2'b00, 1'b0, 4);
    step(2'b00, 1'b1, 1);
    check("door_in_transit", 2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b0, 14);
    check("transit_late", 2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b0, 1);
    check("arrive_despite_door", 2'b10, 1'b0, 1'b1);

    // Asynchronous reset mid-transit takes effect without a clock edge.
    do_reset();
    step(2'b01, 1'b0, 4);
    check("pre_async", 2'b00, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 check("async_reset", 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(2'b00, 1'b0, 2);
    check("post_async", 2'b01, 1'b0, 1'b0);

`ifdef DOOR_SENSE_EN
    do_reset();
    n_cmp++;
    if (dc !== 1'b1) begin n_bad++; $display("FAIL dc_reset: got %b want 1", dc); end
    step(2'b00, 1'b1, 1);
    n_cmp++;
    if (dc !== 1'b0) begin n_bad++; $display("FAIL dc_open: got %b want 0", dc); end
    step(2'b01, 1'b0, 7);
    n_cmp++;
    if (dc !== 1'b0) begin n_bad++; $display("FAIL dc_7: got %b want 0", dc); end
    check("wait_dc", 2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1);
    n_cmp++;
    if (dc !== 1'b1) begin n_bad++; $display("FAIL dc_8: got %b want 1", dc); end
    check("dc_up_no_depart_yet", 2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1);
    check("depart_after_dc", 2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1);
    check("dc_door_transit", 2'b00, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/floor_sensor.md
Name: floor_sensor

Overview:
- Behavioural plant model of the elevator shaft position sensor, used in the randomized elevator environment.
- Observes the controller's direction and door outputs and drives the 2-bit floor-sensor code FS back into the controller.
- Models finite travel time between floors, a "between floors" code, and limit/interlock violations.
- Optionally models the door-closed sensor (DC).

Parameters:
- TRAVEL_CYCLES, 20, clock cycles to move between adjacent floors (legal range 2..255).
- DOOR_CYCLES, 8, clock cycles from door-close command to DC assertion; used only with DOOR_SENSE_EN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- dir  in  2  controller direction: 00 idle, 01 up, 10 down, 11 reserved (treated as idle).
- door  in  1  controller door command: 1 = open, 0 = closed.
- fs  out  2  floor code: 01 floor1, 10 floor2, 11 floor3, 00 between floors.
- moving  out  1  high while in transit between floors.
- err  out  1  sticky violation flag; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): floor=1, fs=01, moving=0, err=0, timer=0, target=1.
- Two states: AT_FLOOR and TRANSIT.
- AT_FLOOR departure:
  - Departs when the closed-door condition holds (door==0, or dc==1 with DOOR_SENSE_EN) and either dir==01 with floor<3, or dir==10 with floor>1.
  - Next cycle after departure: fs=00, moving=1, target=floor±1, timer=TRAVEL_CYCLES-1.
- TRANSIT:
  - timer decrements every cycle.
  - On the cycle timer==0: floor=target, fs=encode(target), moving=0, state=AT_FLOOR.
  - Total from departure edge to fs showing the new floor is exactly TRAVEL_CYCLES cycles.
- Commitment: target is fixed at departure. Changing dir or door mid-transit does not abort or reverse travel.
- err is set, holding fs/floor unchanged, when any of these occurs:
  - AT_FLOOR with dir==01 at floor 3, or dir==10 at floor 1 (limit overrun).
  - AT_FLOOR with dir==01 or 10 while the door is open (interlock violation).
  - TRANSIT with door==1 on any cycle (door opened between floors).
- Idle, or dir==11, in AT_FLOOR: stays put, no error.
- Each new floor is held for at least 1 cycle: departure is evaluated no earlier than the cycle after arrival.
- Mid-operation reset: returns immediately to floor 1, with no travel modelled.
- No combinational paths from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro DOOR_SENSE_EN.
- Defined:
  - Adds output port dc (1 bit): door-closed sensor, reset value 1.
  - When door goes 1, dc drops to 0 on the next cycle.
  - When door goes 0, a counter loads DOOR_CYCLES-1 and dc rises when it expires, DOOR_CYCLES cycles after door fell.
  - A door re-open during the count restarts the close sequence on the next close.
  - The departure interlock uses dc==1 instead of door==0.
- Not defined: no dc port; the interlock uses door==0 directly.

Decomposition:
- Package elevator_pkg holds:
  - dir_t enum (IDLE=00, UP=01, DOWN=10, RSVD=11).
  - FS code constants (FS_NONE=00, FS_F1=01, FS_F2=10, FS_F3=11).
  - Function fs_encode(floor 1..3).
- One natural sub-module, floor_sensor_timer: loadable down-counter with a zero flag. It is reused for both travel and door timing.

Test Plan:
- Reset then idle 50 cycles with dir=00, door=0 -> fs=01, moving=0, err=0 throughout.
- dir=01, door=0 at floor 1 -> fs=00 one cycle after the sampling edge; fs=10 exactly 20 cycles later, moving=0.
- From floor 2, dir=01 held -> reaches fs=11. Continued dir=01 at floor 3 -> err=1, fs stays 11.
- Mid-transit 1->2, switch dir to 10 -> still arrives at fs=10 after 20 cycles. Then descends to fs=01 after a further ≥21 cycles.
- At floor 1, dir=01 with door=1 -> no departure, err=1. Assert rst=0 asynchronously mid-transit -> fs=01, err=0 immediately.
- With DOOR_SENSE_EN: door 1->0 -> dc=1 after 8 cycles. Departure occurs only after dc=1. Door=1 during transit sets err.
